// File: rtl/elevator_call_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_call_scheduler_if
//  Purpose  : Bundles the call buttons, car sensors and indicator/door outputs
//             of the elevator call scheduler into one interface.
//  Modports : master - environment side (drives buttons/sensors, reads status)
//             slave  - scheduler side (reads buttons/sensors, drives status)
//  Signals  : call_req[NUM_FLOORS], overload, firealarm, person_detected (in)
//             pending[NUM_FLOORS], cur_floor[FW], dir_up, moving, door_open,
//             door_closed, fire_mode, seg[7] (out)
//  Revision : 1.0 - initial release
// ============================================================================
interface elevator_call_scheduler_if #(
    parameter int NUM_FLOORS = 4
);
    localparam int FW = $clog2(NUM_FLOORS);

    logic [NUM_FLOORS-1:0] call_req;
    logic                  overload;
    logic                  firealarm;
    logic                  person_detected;
    logic [NUM_FLOORS-1:0] pending;
    logic [FW-1:0]         cur_floor;
    logic                  dir_up;
    logic                  moving;
    logic                  door_open;
    logic                  door_closed;
    logic                  fire_mode;
    logic [6:0]            seg;

    modport master (
        output call_req, overload, firealarm, person_detected,
        input  pending, cur_floor, dir_up, moving, door_open, door_closed,
               fire_mode, seg
    );

    modport slave (
        input  call_req, overload, firealarm, person_detected,
        output pending, cur_floor, dir_up, moving, door_open, door_closed,
               fire_mode, seg
    );
endinterface
`default_nettype wire

// File: rtl/elevator_call_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_call_scheduler
//  Purpose  : Latches hall/car calls and steers an N-floor car with a
//             direction-preserving SCAN policy through IDLE / MOVE / DOOR /
//             FIRE, honouring overload, door obstruction and fire recall.
//  Ports    : clk    - system clock (rising edge)
//             rst_n  - asynchronous active-low reset
//             bus    - elevator_call_scheduler_if.slave (buttons, sensors,
//                      pending calls, floor, direction, door, 7-seg)
//  Options  : SEG_DISPLAY_EN - when defined, seg carries a registered
//             active-low 7-segment code of cur_floor; otherwise seg is blank.
//  Revision : 1.0 - initial release
// ============================================================================
module elevator_call_scheduler #(
    parameter int NUM_FLOORS    = 4,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    elevator_call_scheduler_if.slave    bus
);
    localparam int FW = $clog2(NUM_FLOORS);
    localparam int TW = $clog2(TRAVEL_CYCLES);
    localparam int DW = $clog2(DOOR_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2,
        ST_FIRE = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic [NUM_FLOORS-1:0] pending_q,   pending_d;
    logic [FW-1:0]         cur_floor_q, cur_floor_d;
    logic                  dir_up_q,    dir_up_d;
    // Direction of the hop in flight; kept apart from dir_up so a fire recall
    // can flip dir_up without reversing a half-finished hop.
    logic                  hop_up_q,    hop_up_d;
    logic                  fire_mode_q, fire_mode_d;
    logic [TW-1:0]         travel_q,    travel_d;
    logic [DW-1:0]         door_cnt_q,  door_cnt_d;
    logic                  moving_q;
    logic                  door_open_q;

    logic [NUM_FLOORS-1:0] w_pend_raw;
    logic [NUM_FLOORS-1:0] w_clear;
    logic [FW-1:0]         w_next_floor;
    logic                  w_fire;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v,
                                       input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f) && v[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v,
                                       input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f) && v[i]) r = 1'b1;
        end
        return r;
    endfunction

    // Calls seen this edge count at an arrival floor, so a button pressed on
    // the arrival edge is served (and cleared) instead of being latched late.
    assign w_pend_raw = pending_q | bus.call_req;
    assign w_fire     = fire_mode_q | bus.firealarm;

    // Floor reached at the end of the current hop, clamped to the shaft.
    always_comb begin : p_next_floor
        w_next_floor = cur_floor_q;
        if (hop_up_q && (cur_floor_q != FW'(NUM_FLOORS - 1))) begin
            w_next_floor = cur_floor_q + 1'b1;
        end else if (!hop_up_q && (cur_floor_q != '0)) begin
            w_next_floor = cur_floor_q - 1'b1;
        end
    end

    always_comb begin : p_next_state
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        dir_up_d    = dir_up_q;
        hop_up_d    = hop_up_q;
        fire_mode_d = fire_mode_q;
        travel_d    = '0;
        door_cnt_d  = '0;

        case (state_q)
            ST_IDLE: begin
                // fire_mode also recalls: the door may have closed at an
                // upper floor on an alarm that has since dropped.
                if (bus.firealarm || fire_mode_q) begin
                    fire_mode_d = 1'b1;
                    if (cur_floor_q == '0) begin
                        state_d = ST_FIRE;
                    end else begin
                        state_d  = ST_MOVE;
                        dir_up_d = 1'b0;
                        hop_up_d = 1'b0;
                    end
                end else if (bus.overload) begin
                    state_d = ST_IDLE;
                end else if (pending_q[cur_floor_q]) begin
                    state_d = ST_DOOR;
                end else if (dir_up_q && any_above(pending_q, cur_floor_q)) begin
                    state_d  = ST_MOVE;
                    hop_up_d = 1'b1;
                end else if (any_below(pending_q, cur_floor_q)) begin
                    state_d  = ST_MOVE;
                    dir_up_d = 1'b0;
                    hop_up_d = 1'b0;
                end else if (any_above(pending_q, cur_floor_q)) begin
                    state_d  = ST_MOVE;
                    dir_up_d = 1'b1;
                    hop_up_d = 1'b1;
                end
            end

            ST_MOVE: begin
                if (bus.firealarm) begin
                    fire_mode_d = 1'b1;
                    dir_up_d    = 1'b0;
                end
                if (travel_q == TW'(TRAVEL_CYCLES - 1)) begin
                    cur_floor_d = w_next_floor;
                    if (w_fire) begin
                        if (w_next_floor == '0) begin
                            state_d = ST_FIRE;
                        end else begin
                            hop_up_d = 1'b0;
                        end
                    end else if (w_pend_raw[w_next_floor]) begin
                        state_d = ST_DOOR;
                    end else if (dir_up_q && any_above(w_pend_raw, w_next_floor)) begin
                        hop_up_d = 1'b1;
                    end else if (!dir_up_q && any_below(w_pend_raw, w_next_floor)) begin
                        hop_up_d = 1'b0;
                    end else if (dir_up_q && any_below(w_pend_raw, w_next_floor)) begin
                        dir_up_d = 1'b0;
                        hop_up_d = 1'b0;
                    end else if (!dir_up_q && any_above(w_pend_raw, w_next_floor)) begin
                        dir_up_d = 1'b1;
                        hop_up_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    travel_d = travel_q + 1'b1;
                end
            end

            ST_DOOR: begin
                if (bus.firealarm) begin
                    fire_mode_d = 1'b1;
                    state_d     = (cur_floor_q == '0) ? ST_FIRE : ST_IDLE;
                end else if (bus.overload || bus.person_detected ||
                             bus.call_req[cur_floor_q]) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q == DW'(DOOR_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    door_cnt_d = door_cnt_q + 1'b1;
                end
            end

            ST_FIRE: begin
                fire_mode_d = 1'b1;
                if (!bus.firealarm) begin
                    state_d     = ST_IDLE;
                    fire_mode_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A floor being (or about to be) served has its call dropped; the clear
    // beats a same-edge press of that button.
    always_comb begin : p_pending
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_clear[i] = (state_d == ST_DOOR) && (cur_floor_d == FW'(i));
        end
        if (bus.firealarm || (state_q == ST_FIRE)) begin
            pending_d = '0;
        end else begin
            pending_d = w_pend_raw & ~w_clear;
        end
    end

`ifdef SEG_DISPLAY_EN
    logic [6:0] seg_q;

    function automatic logic [6:0] seg_code(input logic [FW-1:0] f);
        logic [6:0] s;
        case (int'(f))
            0:       s = 7'b1000000;
            1:       s = 7'b1111001;
            2:       s = 7'b0100100;
            3:       s = 7'b0110000;
            4:       s = 7'b0011001;
            5:       s = 7'b0010010;
            6:       s = 7'b0000010;
            7:       s = 7'b1111000;
            8:       s = 7'b0000000;
            9:       s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            cur_floor_q <= '0;
            dir_up_q    <= 1'b1;
            hop_up_q    <= 1'b1;
            fire_mode_q <= 1'b0;
            travel_q    <= '0;
            door_cnt_q  <= '0;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
`ifdef SEG_DISPLAY_EN
            seg_q       <= 7'b1000000;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cur_floor_q <= cur_floor_d;
            dir_up_q    <= dir_up_d;
            hop_up_q    <= hop_up_d;
            fire_mode_q <= fire_mode_d;
            travel_q    <= travel_d;
            door_cnt_q  <= door_cnt_d;
            moving_q    <= (state_d == ST_MOVE);
            door_open_q <= (state_d == ST_DOOR) || (state_d == ST_FIRE);
`ifdef SEG_DISPLAY_EN
            seg_q       <= seg_code(cur_floor_d);
`endif
        end
    end

    assign bus.pending     = pending_q;
    assign bus.cur_floor   = cur_floor_q;
    assign bus.dir_up      = dir_up_q;
    assign bus.moving      = moving_q;
    assign bus.door_open   = door_open_q;
    assign bus.door_closed = ~door_open_q;
    assign bus.fire_mode   = fire_mode_q;
`ifdef SEG_DISPLAY_EN
    assign bus.seg         = seg_q;
`else
    assign bus.seg         = 7'b1111111;
`endif

endmodule
`default_nettype wire

// File: tb/tb_elevator_call_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elevator_call_scheduler
//  Purpose  : Self-checking bench for elevator_call_scheduler. Each call that
//             should be answered pushes its expected service floor into a
//             queue; every door-open event pops and compares it. Timing and
//             override behaviour are checked directly at known edges.
//  Options  : SEG_DISPLAY_EN selects the expected seg patterns.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_call_scheduler;
    localparam int NUM_FLOORS    = 4;
    localparam int TRAVEL_CYCLES = 8;
    localparam int DOOR_CYCLES   = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   exp_q[$];
    logic door_prev;

    elevator_call_scheduler_if #(.NUM_FLOORS(NUM_FLOORS)) bus ();

    elevator_call_scheduler #(
        .NUM_FLOORS    (NUM_FLOORS),
        .TRAVEL_CYCLES (TRAVEL_CYCLES),
        .DOOR_CYCLES   (DOOR_CYCLES)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : g_watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int f);
        logic [6:0] pat;
        case (f)
            0:       pat = 7'b1000000;
            1:       pat = 7'b1111001;
            2:       pat = 7'b0100100;
            3:       pat = 7'b0110000;
            default: pat = 7'b1111111;
        endcase
`ifdef SEG_DISPLAY_EN
        return pat;
`else
        return pat | 7'b1111111;
`endif
    endfunction

    // Scoreboard: every rising door_open must match the oldest expected floor.
    task automatic sb_sample();
        if (bus.door_open && !door_prev) begin
            if (exp_q.size() == 0) check("sb_door_extra", 32'(bus.cur_floor), 32'hFF);
            else                   check("sb_door_floor", 32'(bus.cur_floor), exp_q.pop_front());
        end
        door_prev = bus.door_open;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sb_sample();
    endtask

    task automatic pulse_call(input logic [NUM_FLOORS-1:0] c);
        bus.call_req = c;
        tick();
        bus.call_req = '0;
    endtask

    task automatic wait_door_open(input int budget);
        int n = 0;
        while (!bus.door_open && n < budget) begin tick(); n++; end
        check("wait_door_open", 32'(bus.door_open), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.door_open || bus.moving) && n < budget) begin tick(); n++; end
        check("wait_idle", 32'(bus.door_open | bus.moving), 0);
    endtask

    task automatic wait_floor(input int f, input int budget);
        int n = 0;
        while (int'(bus.cur_floor) != f && n < budget) begin tick(); n++; end
        check("wait_floor", 32'(bus.cur_floor), 32'(f));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pending"},   32'(bus.pending),     0);
        check({tag, "_floor"},     32'(bus.cur_floor),   0);
        check({tag, "_dir_up"},    32'(bus.dir_up),      1);
        check({tag, "_moving"},    32'(bus.moving),      0);
        check({tag, "_door_open"}, 32'(bus.door_open),   0);
        check({tag, "_door_clsd"}, 32'(bus.door_closed), 1);
        check({tag, "_fire"},      32'(bus.fire_mode),   0);
        check({tag, "_seg"},       32'(bus.seg),         32'(exp_seg(0)));
    endtask

    initial begin : g_stim
        n_checks            = 0;
        n_errors            = 0;
        door_prev           = 1'b0;
        rst_n               = 1'b0;
        bus.call_req        = '0;
        bus.overload        = 1'b0;
        bus.firealarm       = 1'b0;
        bus.person_detected = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst_n = 1'b1;
        tick();
        tick();

        // Single call to floor 2 from idle at G: exact travel/door timing.
        exp_q.push_back(2);
        pulse_call(4'b0100);                                   // edge 0
        check("t1_pending_e0", 32'(bus.pending), 4);
        check("t1_moving_e0",  32'(bus.moving),  0);
        tick();                                                // edge 1
        check("t1_moving_e1",  32'(bus.moving),  1);
        repeat (7) tick();                                     // edge 8
        check("t1_floor_e8",   32'(bus.cur_floor), 0);
        tick();                                                // edge 9
        check("t1_floor_e9",   32'(bus.cur_floor), 1);
        repeat (8) tick();                                     // edge 17
        check("t1_floor_e17",  32'(bus.cur_floor), 2);
        check("t1_door_e17",   32'(bus.door_open), 1);
        check("t1_pend_e17",   32'(bus.pending),   0);
        check("t1_seg_e17",    32'(bus.seg),       32'(exp_seg(2)));
        repeat (3) tick();                                     // edge 20
        check("t1_door_e20",   32'(bus.door_open), 1);
        tick();                                                // edge 21
        check("t1_door_e21",   32'(bus.door_open),   0);
        check("t1_closed_e21", 32'(bus.door_closed), 1);
        check("t1_moving_e21", 32'(bus.moving),      0);

        // SCAN: at floor 1 going up with pending 1001 -> serve 3, reverse, 0.
        exp_q.push_back(0);
        pulse_call(4'b0001);
        wait_door_open(60);
        wait_idle(20);
        exp_q.push_back(3);
        exp_q.push_back(0);
        pulse_call(4'b1000);
        wait_floor(1, 30);
        check("t2_dir_up_f1", 32'(bus.dir_up), 1);
        pulse_call(4'b0001);
        check("t2_pending",   32'(bus.pending), 9);
        wait_door_open(60);
        check("t2_floor3",    32'(bus.cur_floor), 3);
        wait_idle(20);
        wait_door_open(60);
        check("t2_floor0",    32'(bus.cur_floor), 0);
        check("t2_dir_down",  32'(bus.dir_up),    0);
        wait_idle(20);

        // Obstruction: person held 5 edges keeps the door open 5+DOOR_CYCLES.
        exp_q.push_back(2);
        pulse_call(4'b0100);
        wait_door_open(60);
        bus.person_detected = 1'b1;
        repeat (5) tick();
        bus.person_detected = 1'b0;
        repeat (DOOR_CYCLES - 1) tick();
        check("t3_door_last", 32'(bus.door_open), 1);
        tick();
        check("t3_door_shut", 32'(bus.door_open), 0);

        // Overload in IDLE blocks departure until it drops.
        bus.overload = 1'b1;
        exp_q.push_back(0);
        pulse_call(4'b0001);
        check("t3_ovl_pend",  32'(bus.pending), 1);
        repeat (10) tick();
        check("t3_ovl_hold",  32'(bus.moving),  0);
        bus.overload = 1'b0;
        tick();
        check("t3_ovl_go",    32'(bus.moving),  1);
        wait_door_open(60);
        wait_idle(20);

        // Fire recall mid-hop 2->3 with pending 1010.
        exp_q.push_back(0);
        pulse_call(4'b1000);
        wait_floor(2, 40);
        pulse_call(4'b0010);
        check("t4_pending",   32'(bus.pending), 10);
        tick();
        bus.firealarm = 1'b1;
        tick();
        check("t4_pend_clr",  32'(bus.pending),   0);
        check("t4_fire_mode", 32'(bus.fire_mode), 1);
        check("t4_dir_down",  32'(bus.dir_up),    0);
        check("t4_moving",    32'(bus.moving),    1);
        wait_floor(3, 20);
        wait_door_open(60);
        check("t4_fire_floor", 32'(bus.cur_floor), 0);
        check("t4_fire_mv",    32'(bus.moving),    0);
        repeat (3) tick();
        check("t4_fire_door",  32'(bus.door_open), 1);
        check("t4_fire_flag",  32'(bus.fire_mode), 1);
        bus.firealarm = 1'b0;
        tick();
        check("t4_fire_exit",  32'(bus.fire_mode), 0);
        check("t4_door_shut",  32'(bus.door_open), 0);

        // Same-floor call in IDLE: door one edge after the call latches.
        exp_q.push_back(0);
        pulse_call(4'b0001);
        check("t5_same_wait", 32'(bus.door_open), 0);
        check("t5_same_pend", 32'(bus.pending),   1);
        tick();
        check("t5_same_door", 32'(bus.door_open), 1);
        check("t5_same_stay", 32'(bus.moving),    0);
        check("t5_same_clr",  32'(bus.pending),   0);
        wait_idle(20);

        // Press of the arrival floor on the arrival edge is cleared.
        exp_q.push_back(2);
        pulse_call(4'b0100);
        wait_floor(1, 30);
        repeat (TRAVEL_CYCLES - 1) tick();
        bus.call_req = 4'b0100;
        tick();
        bus.call_req = '0;
        check("t5_race_floor", 32'(bus.cur_floor), 2);
        check("t5_race_door",  32'(bus.door_open), 1);
        check("t5_race_pend",  32'(bus.pending),   0);
        wait_idle(20);

        // Asynchronous reset while moving up from floor 2.
        pulse_call(4'b1000);
        repeat (3) tick();
        check("t6_pre_moving", 32'(bus.moving), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("t6_async");
        door_prev = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t6_post_floor", 32'(bus.cur_floor), 0);
        check("t6_post_move",  32'(bus.moving),    0);
        check("t6_post_pend",  32'(bus.pending),   0);

        check("sb_drain", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
